// File: rtl/tcp_tx_arb_pkg.sv
// Shared types for the TCP TX arbiter: segment header, FSM states, header reset value.
// No logic or latency of its own; pure type and constant definitions.
// Backpressure: not applicable.
package tcp_tx_arb_pkg;

    typedef struct packed {
        logic        syn_flag;
        logic        ack_flag;
        logic        rst_flag;
        logic        fin_flag;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } tcp_hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } tcp_tx_arb_state_t;

    localparam tcp_hdr_t TCP_HDR_RST = '0;

endpackage

// File: rtl/tcp_rr_picker.sv
// Round-robin search: first set bit of mask at or after ptr, wrapping modulo N_CONN.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when the mask is empty.
module tcp_rr_picker #(
    parameter int N_CONN = 4
) (
    input  logic [N_CONN-1:0]         mask,
    input  logic [$clog2(N_CONN)-1:0] ptr,
    output logic                      found,
    output logic [$clog2(N_CONN)-1:0] idx
);

    localparam int IW = $clog2(N_CONN);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = N_CONN - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_CONN)) begin
                sum = sum - (IW+1)'(N_CONN);
            end
            cand = sum[IW-1:0];
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter sharing one TCP TX engine; TCP_TX_ARB_RST_PRIO_EN lets RST segments jump the queue.
// Latency: req_rdy same cycle as grant, tx_vld one cycle later; minimum 2 cycles between grants.
// Backpressure: no grant while busy; holds the engine until tx_done or abort after TIMEOUT_CYC cycles.
module tcp_tx_arbiter
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_CONN      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CONN-1:0]         req_vld,
    output logic [N_CONN-1:0]         req_rdy,
    input  tcp_hdr_t [N_CONN-1:0]     req_hdr,
    output logic                      tx_vld,
    input  logic                      tx_eng_acc,
    input  logic                      tx_done,
    output tcp_hdr_t                  tx_hdr,
    output logic [$clog2(N_CONN)-1:0] grant_id,
    output logic                      busy,
    output logic                      tx_abort
);

    localparam int IW = $clog2(N_CONN);
    localparam int CW = $clog2(TIMEOUT_CYC);

    tcp_tx_arb_state_t state_q, state_d;
    logic [IW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              found_all;
    logic [IW-1:0]     idx_all;
    logic [IW-1:0]     win;
    logic              grant;
    logic              timeout;
    logic              abort_d;

    tcp_rr_picker #(.N_CONN(N_CONN)) u_pick_all (
        .mask  (req_vld),
        .ptr   (ptr_q),
        .found (found_all),
        .idx   (idx_all)
    );

`ifdef TCP_TX_ARB_RST_PRIO_EN
    logic [N_CONN-1:0] rst_mask;
    logic              found_rst;
    logic [IW-1:0]     idx_rst;

    always_comb begin
        rst_mask = '0;
        for (int i = 0; i < N_CONN; i++) begin
            rst_mask[i] = req_vld[i] & req_hdr[i].rst_flag;
        end
    end

    tcp_rr_picker #(.N_CONN(N_CONN)) u_pick_rst (
        .mask  (rst_mask),
        .ptr   (ptr_q),
        .found (found_rst),
        .idx   (idx_rst)
    );

    assign win = found_rst ? idx_rst : idx_all;
`else
    assign win = idx_all;
`endif

    assign grant = (state_q == IDLE) && found_all;

    // Held low while reset is asserted so no requester sees a phantom accept.
    always_comb begin
        req_rdy = '0;
        if (grant && rst) begin
            req_rdy[win] = 1'b1;
        end
    end

    // Fires on the cycle the counter would step to TIMEOUT_CYC-1; abort lands with that value.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 2));

    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_eng_acc) begin
                    state_d = tx_done ? IDLE : WAIT_DONE;
                end
                if (timeout) begin
                    state_d = IDLE;
                    abort_d = ~tx_done;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tx_vld   <= 1'b0;
            tx_hdr   <= TCP_HDR_RST;
            grant_id <= '0;
            busy     <= 1'b0;
            tx_abort <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_vld   <= (state_d == ISSUE);
            busy     <= (state_d != IDLE);
            tx_abort <= abort_d;
            if (grant) begin
                tx_hdr   <= req_hdr[win];
                grant_id <= win;
                ptr_q    <= (win == IW'(N_CONN - 1)) ? '0 : win + IW'(1);
                cnt_q    <= '0;
            end else if (state_q != IDLE && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: expected grants queued at stimulus, checked when tx_vld rises.
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;
    import tcp_tx_arb_pkg::*;

    localparam int NC = 4;
    localparam int TO = 32;

    typedef struct {
        int       id;
        tcp_hdr_t hdr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   req_vld;
    logic [NC-1:0]   req_rdy;
    tcp_hdr_t [NC-1:0] req_hdr;
    logic            tx_vld;
    logic            tx_eng_acc;
    logic            tx_done;
    tcp_hdr_t        tx_hdr;
    logic [1:0]      grant_id;
    logic            busy;
    logic            tx_abort;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   p_m = 0;
    int   eng_mode = 0;  // 0: driven by hand, 1: accept+done at once, 2: accept, never done
    logic vld_prev = 1'b0;
    logic [NC-1:0] fair_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    tcp_tx_arbiter #(.N_CONN(NC), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_hdr    (req_hdr),
        .tx_vld     (tx_vld),
        .tx_eng_acc (tx_eng_acc),
        .tx_done    (tx_done),
        .tx_hdr     (tx_hdr),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx_abort   (tx_abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NC-1:0] m, input int p);
        int j;
        for (int k = 0; k < NC; k++) begin
            j = (p + k) % NC;
            if (m[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic tcp_hdr_t mk_hdr(input logic [31:0] seq, input logic [31:0] ack,
                                        input logic rf, input logic [15:0] port);
        tcp_hdr_t h;
        h.syn_flag = 1'b0;
        h.ack_flag = 1'b1;
        h.rst_flag = rf;
        h.fin_flag = 1'b0;
        h.seq      = seq;
        h.ack      = ack;
        h.src_port = port;
        h.dst_port = 16'd80;
        return h;
    endfunction

    // Reference choice of winner for the current mask, queued for the tx_vld monitor.
    task automatic push_grant(input logic [NC-1:0] m, output int w);
        exp_t e;
`ifdef TCP_TX_ARB_RST_PRIO_EN
        logic [NC-1:0] rm;
        for (int i = 0; i < NC; i++) rm[i] = m[i] & req_hdr[i].rst_flag;
        w = rr_pick(rm, p_m);
        if (w < 0) w = rr_pick(m, p_m);
`else
        w = rr_pick(m, p_m);
`endif
        e.id  = w;
        e.hdr = req_hdr[w[1:0]];
        sb.push_back(e);
        p_m = (w + 1) % NC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (eng_mode == 1) begin
            tx_eng_acc = tx_vld;
            tx_done    = tx_vld;
        end else if (eng_mode == 2) begin
            tx_eng_acc = tx_vld;
            tx_done    = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (tx_vld && !vld_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_issue", {126'd0, tx_vld}, 128'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_grant_id", grant_id, e.id);
                chk("sb_tx_hdr", tx_hdr, e.hdr);
            end
        end
        vld_prev = tx_vld;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int w;
        int ng;
        int gcyc[5];
        int t_issue;
        int t_abort;
        logic saw;
        logic [NC-1:0] first_oh;

        rst = 1'b0; req_vld = '0; tx_eng_acc = 1'b0; tx_done = 1'b0;
        for (int i = 0; i < NC; i++)
            req_hdr[i] = mk_hdr(32'h1000 * (i + 1), 32'h20 + i, 1'b0, 16'(5000 + i));

        #12;
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_tx_vld", tx_vld, 0);
        chk("rst_tx_hdr", tx_hdr, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_abort", tx_abort, 0);
        tick(); rst = 1'b1;

        // Single request on connection 2
        req_hdr[2] = mk_hdr(32'h7D0, 32'h11, 1'b0, 16'd4002);
        tick(); req_vld = 4'b0100; push_grant(req_vld, w);
        @(negedge clk); chk("t1_rdy_same_cycle", req_rdy, 4'b0100);
        tick(); req_vld = '0; tx_eng_acc = 1'b1;
        @(negedge clk);
        chk("t1_tx_vld", tx_vld, 1);
        chk("t1_seq", tx_hdr.seq, 32'h7D0);
        chk("t1_grant_id", grant_id, 2);
        chk("t1_busy", busy, 1);
        tick(); tx_eng_acc = 1'b0;
        @(negedge clk);
        chk("t1_wait_vld_low", tx_vld, 0);
        chk("t1_wait_busy", busy, 1);
        tick(); tx_done = 1'b1;
        @(negedge clk);
        tick(); tx_done = 1'b0;
        @(negedge clk); chk("t1_back_idle", busy, 0);

        // Async reset during WAIT_DONE
        tick(); req_vld = 4'b0010; push_grant(req_vld, w);
        @(negedge clk); chk("r_rdy", req_rdy, 4'b0010);
        tick(); req_vld = 4'b1000; tx_eng_acc = 1'b1;
        @(negedge clk); chk("r_no_grant_while_busy", req_rdy, 0);
        tick(); tx_eng_acc = 1'b0;
        @(negedge clk); chk("r_in_wait_done", {1'b0, busy & ~tx_vld}, 2'd1);
        #1 rst = 1'b0; req_vld = 4'b1111;
        #1;
        chk("r_async_busy", busy, 0);
        chk("r_async_tx_vld", tx_vld, 0);
        chk("r_async_grant_id", grant_id, 0);
        chk("r_async_tx_hdr", tx_hdr, 0);
        chk("r_async_req_rdy", req_rdy, 0);
        chk("r_async_tx_abort", tx_abort, 0);
        tick();
        eng_mode = 1;
        tick(); rst = 1'b1;
        p_m = 0;

        // Fairness: all four held, engine completes immediately
        for (int k = 0; k < 5; k++) push_grant(4'b1111, w);
        ng = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            @(negedge clk);
            if (req_rdy != '0) begin
                chk("fair_order", req_rdy, fair_ord[ng]);
                gcyc[ng] = cyc;
                ng++;
            end
            tick();
            if (ng == 5) req_vld = '0;
        end
        chk("fair_grant_count", ng, 5);
        for (int k = 1; k < 5; k++) chk("fair_gap", gcyc[k] - gcyc[k-1], 2);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("fair_acc_done_idle", busy, 0);
        chk("fair_no_abort", tx_abort, 0);

        // Timeout: connection 1 accepted but never completed
        eng_mode = 2;
        tick(); req_vld = 4'b0010; push_grant(req_vld, w);
        @(negedge clk); chk("to_rdy", req_rdy, 4'b0010);
        tick(); req_vld = '0; t_issue = cyc;
        t_abort = -1;
        for (int k = 0; k < 2 * TO && t_abort < 0; k++) begin
            @(negedge clk);
            if (tx_abort) begin
                t_abort = cyc;
                chk("to_busy_clear", busy, 0);
            end
            tick();
        end
        chk("to_latency", t_abort - t_issue, TO - 1);
        @(negedge clk); chk("to_single_pulse", tx_abort, 0);
        eng_mode = 1;
        tick(); req_vld = 4'b0101; push_grant(req_vld, w);
        @(negedge clk); chk("to_next_grant", req_rdy, 4'b0100);
        tick(); req_vld = '0;
        @(negedge clk);
        tick();
        @(negedge clk); chk("to_next_idle", busy, 0);

        // tx_done on the timeout cycle wins over the abort
        eng_mode = 0;
        tick(); req_vld = 4'b0001; push_grant(req_vld, w);
        @(negedge clk); chk("tod_rdy_wrap", req_rdy, 4'b0001);
        tick(); req_vld = '0; tx_eng_acc = 1'b1;
        saw = 1'b0;
        for (int k = 1; k <= TO - 2; k++) begin
            @(negedge clk); saw |= tx_abort;
            tick(); tx_eng_acc = 1'b0;
        end
        tx_done = 1'b1;
        @(negedge clk); saw |= tx_abort;
        tick(); tx_done = 1'b0;
        @(negedge clk); saw |= tx_abort;
        chk("tod_idle", busy, 0);
        tick();
        @(negedge clk); saw |= tx_abort;
        chk("tod_no_abort", saw, 0);

        // RST-flag priority from p=0
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        p_m = 0;
        req_hdr[0] = mk_hdr(32'hA0, 32'h1, 1'b0, 16'd6000);
        req_hdr[3] = mk_hdr(32'hA3, 32'h2, 1'b1, 16'd6003);
        eng_mode = 1;
        tick(); req_vld = 4'b1001; push_grant(req_vld, w);
`ifdef TCP_TX_ARB_RST_PRIO_EN
        first_oh = 4'b1000;
`else
        first_oh = 4'b0001;
`endif
        @(negedge clk); chk("prio_first", req_rdy, first_oh);
        tick(); req_vld = 4'b1001 & ~first_oh; push_grant(req_vld, w);
        @(negedge clk);
        tick();
        @(negedge clk); chk("prio_second", req_rdy, 4'b1001 & ~first_oh);
        tick(); req_vld = '0;
        @(negedge clk);
        tick();
        @(negedge clk); chk("prio_idle", busy, 0);

        tick();
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
